// File: rtl/addsub_mc_if.sv
// Handshake bundle between the ALU sequencer and the multi-cycle add/subtract
// unit: an operation request channel (IN_ALU) and a result channel (OUT_ALU).
interface addsub_mc_if #(
    parameter int DATA_SIZE = 16,
    parameter int ID_SIZE   = 8
) ();

    logic                            in_valid;
    logic                            in_ready;
    logic [1:0]                      op;
    logic [DATA_SIZE-1:0]            opa;
    logic [DATA_SIZE-1:0]            opb;
    logic                            c_in;
    logic [ID_SIZE-1:0]              id;
    logic                            out_valid;
    logic                            out_ready;
    logic [ID_SIZE+4+DATA_SIZE-1:0]  result;

    modport master (
        output in_valid, op, opa, opb, c_in, id, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, opa, opb, c_in, id, out_ready,
        output in_ready, out_valid, result
    );

endinterface

// File: rtl/addsub_mc.sv
// Multi-cycle add/subtract unit. Operands are captured once, then summed
// CHUNK_SIZE bits per cycle with the carry held in a register between slices.
// Subtraction is done as A + ~B + 1 (SBB uses ~c_in as the incoming carry).
module addsub_mc #(
    parameter int DATA_SIZE  = 16,
    parameter int CHUNK_SIZE = 4,
    parameter int ID_SIZE    = 8
) (
    input logic        clk,
    input logic        rst,
    addsub_mc_if.slave bus
);

    localparam int NCHUNK = DATA_SIZE / CHUNK_SIZE;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int RES_W  = ID_SIZE + 4 + DATA_SIZE;
    localparam int MSB    = DATA_SIZE - 1;

    localparam logic [CNT_W-1:0]     LAST_CNT   = CNT_W'(NCHUNK - 1);
    localparam logic [DATA_SIZE-1:0] SLICE_MASK = DATA_SIZE'({CHUNK_SIZE{1'b1}});

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                 r_state;
    logic [DATA_SIZE-1:0]   r_a;
    logic [DATA_SIZE-1:0]   r_b;
    logic [DATA_SIZE-1:0]   r_sum;
    logic                   r_carry;
    logic                   r_isSub;
    logic [ID_SIZE-1:0]     r_id;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_outValid;
    logic [RES_W-1:0]       r_result;

    logic                   w_inReady;
    logic [31:0]            w_shift;
    logic [CHUNK_SIZE-1:0]  w_sliceA;
    logic [CHUNK_SIZE-1:0]  w_sliceB;
    logic [CHUNK_SIZE:0]    w_sliceSum;
    logic [DATA_SIZE-1:0]   w_sumFull;
    logic                   w_lastSlice;
    logic                   w_carryFlag;
    logic                   w_ovf;
    logic                   w_neg;
    logic                   w_zero;
    logic                   w_initCarry;
    logic [DATA_SIZE-1:0]   w_bPrime;

    // Ready is held low while reset is asserted so nothing is accepted then.
    assign w_inReady     = (r_state == IDLE) && !rst;
    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = r_outValid;
    assign bus.result    = r_result;

    // Odd opcodes (SUB, SBB) subtract; ADC/SBB take the external carry.
    assign w_bPrime    = bus.op[0] ? ~bus.opb : bus.opb;
    assign w_initCarry = bus.op[1] ? (bus.c_in ^ bus.op[0]) : bus.op[0];

    // Current slice of each operand and its sum with the running carry.
    assign w_shift    = 32'(r_cnt) * 32'(CHUNK_SIZE);
    assign w_sliceA   = CHUNK_SIZE'(r_a >> w_shift);
    assign w_sliceB   = CHUNK_SIZE'(r_b >> w_shift);
    assign w_sliceSum = {1'b0, w_sliceA} + {1'b0, w_sliceB}
                      + {{CHUNK_SIZE{1'b0}}, r_carry};

    // Sum register with the current slice merged in, so the flags can be
    // taken in the same cycle that the last slice is produced.
    assign w_sumFull = (r_sum & ~(SLICE_MASK << w_shift))
                     | (DATA_SIZE'(w_sliceSum[CHUNK_SIZE-1:0]) << w_shift);

    assign w_lastSlice = (r_cnt == LAST_CNT);
    assign w_carryFlag = w_sliceSum[CHUNK_SIZE] ^ r_isSub;
    assign w_ovf       = (r_a[MSB] == r_b[MSB]) && (w_sumFull[MSB] != r_a[MSB]);
    assign w_neg       = w_sumFull[MSB];
    assign w_zero      = (w_sumFull == '0);

    // Control FSM plus datapath registers: capture, slice-by-slice add, hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_isSub    <= 1'b0;
            r_id       <= '0;
            r_cnt      <= '0;
            r_outValid <= 1'b0;
            r_result   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.opa;
                        r_b     <= w_bPrime;
                        r_id    <= bus.id;
                        r_isSub <= bus.op[0];
                        r_carry <= w_initCarry;
                        r_cnt   <= '0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_sum   <= w_sumFull;
                    r_carry <= w_sliceSum[CHUNK_SIZE];
                    if (w_lastSlice) begin
                        r_cnt      <= '0;
                        r_result   <= {r_id, w_ovf, w_carryFlag, w_neg, w_zero, w_sumFull};
                        r_outValid <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_outValid <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_mc.sv
// Bench for addsub_mc: three units (slice widths 1, 4 and 16) share one
// stimulus stream and are compared against an arithmetic reference model.
module tb_addsub_mc;

    localparam int DS = 16;
    localparam int IS = 8;
    localparam int RW = IS + 4 + DS;
    localparam int NI = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NI-1:0]    inValid = '0;
    logic [NI-1:0]    outReady = '0;
    logic [1:0]       opT = '0;
    logic [DS-1:0]    opaT = '0;
    logic [DS-1:0]    opbT = '0;
    logic             cInT = 1'b0;
    logic [IS-1:0]    idT = '0;

    wire  [NI-1:0]    inReady;
    wire  [NI-1:0]    outValid;
    wire  [RW-1:0]    resultV [NI];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // One unit per slice width, all fed from the same stimulus signals.
    for (genvar g = 0; g < NI; g++) begin : gInst
        localparam int CS = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
        addsub_mc_if #(.DATA_SIZE(DS), .ID_SIZE(IS)) ifc ();
        assign ifc.in_valid  = inValid[g];
        assign ifc.out_ready = outReady[g];
        assign ifc.op        = opT;
        assign ifc.opa       = opaT;
        assign ifc.opb       = opbT;
        assign ifc.c_in      = cInT;
        assign ifc.id        = idT;
        assign inReady[g]    = ifc.in_ready;
        assign outValid[g]   = ifc.out_valid;
        assign resultV[g]    = ifc.result;
        addsub_mc #(.DATA_SIZE(DS), .CHUNK_SIZE(CS), .ID_SIZE(IS)) dut (
            .clk (clk),
            .rst (rst),
            .bus (ifc)
        );
    end

    function automatic int nchOf(input int g);
        return (g == 0) ? 16 : ((g == 1) ? 4 : 1);
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic logic [RW-1:0] refModel(input logic [1:0] op, input logic [DS-1:0] a,
                                               input logic [DS-1:0] b, input logic cin,
                                               input logic [IS-1:0] id);
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int c  = (op >= 2'd2) ? int'(cin) : 0;
        int uRes;
        int sRes;
        logic carry;
        logic ovf;
        logic [DS-1:0] sum;
        if (op == 2'd0 || op == 2'd2) begin
            uRes  = ua + ub + c;
            sRes  = sa + sb + c;
            carry = (uRes > 65535);
        end else begin
            uRes  = ua - ub - c;
            sRes  = sa - sb - c;
            carry = (uRes < 0);
        end
        sum = uRes[DS-1:0];
        ovf = (sRes > 32767) || (sRes < -32768);
        return {id, ovf, carry, sum[DS-1], (sum == '0), sum};
    endfunction

    function automatic logic [DS-1:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one operation to every unit and let it be accepted on one edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [DS-1:0] a,
                                 input logic [DS-1:0] b, input logic cin,
                                 input logic [IS-1:0] id);
        opT = op; opaT = a; opbT = b; cInT = cin; idT = id;
        inValid = '1;
        for (int g = 0; g < NI; g++)
            checkOutput($sformatf("ready_at_accept_u%0d", g), 32'(inReady[g]), 32'd1);
        stepClock();
        inValid = '0;
    endtask

    // Wait (bounded) for every unit's result, checking latency and value.
    task automatic waitResults(input string tag, input logic [RW-1:0] expected);
        int lat [NI];
        bit allSeen;
        for (int g = 0; g < NI; g++) lat[g] = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            stepClock();
            allSeen = 1'b1;
            for (int g = 0; g < NI; g++) begin
                if (outValid[g] && lat[g] == 0) lat[g] = cyc;
                if (lat[g] == 0) allSeen = 1'b0;
            end
            if (allSeen) break;
        end
        for (int g = 0; g < NI; g++) begin
            checkOutput($sformatf("%s_latency_u%0d", tag, g), 32'(lat[g]), 32'(nchOf(g)));
            checkOutput($sformatf("%s_result_u%0d", tag, g), 32'(resultV[g]), 32'(expected));
        end
    endtask

    task automatic releaseOutputs(input string tag);
        outReady = '1;
        stepClock();
        outReady = '0;
        for (int g = 0; g < NI; g++) begin
            checkOutput($sformatf("%s_idle_ready_u%0d", tag, g), 32'(inReady[g]), 32'd1);
            checkOutput($sformatf("%s_valid_drop_u%0d", tag, g), 32'(outValid[g]), 32'd0);
        end
    endtask

    initial begin
        logic [RW-1:0] expected;
        int seen;

        // Power-on reset held for two cycles.
        rst = 1'b1;
        stepClock();
        stepClock();
        for (int g = 0; g < NI; g++) begin
            checkOutput($sformatf("rst_ready_u%0d", g), 32'(inReady[g]), 32'd0);
            checkOutput($sformatf("rst_valid_u%0d", g), 32'(outValid[g]), 32'd0);
            checkOutput($sformatf("rst_result_u%0d", g), 32'(resultV[g]), 32'd0);
        end
        rst = 1'b0;
        #1;
        for (int g = 0; g < NI; g++)
            checkOutput($sformatf("post_rst_ready_u%0d", g), 32'(inReady[g]), 32'd1);
        @(negedge clk);

        // Directed cases with hand-computed results.
        applyStimulus(2'd0, 16'h7FFF, 16'h0001, 1'b0, 8'h5A);
        waitResults("add_ovf", {8'h5A, 4'b1010, 16'h8000});
        releaseOutputs("add_ovf");

        applyStimulus(2'd1, 16'h0003, 16'h0005, 1'b0, 8'h11);
        waitResults("sub_borrow", {8'h11, 4'b0110, 16'hFFFE});
        releaseOutputs("sub_borrow");

        applyStimulus(2'd1, 16'h1234, 16'h1234, 1'b0, 8'h22);
        waitResults("sub_zero", {8'h22, 4'b0001, 16'h0000});
        releaseOutputs("sub_zero");

        applyStimulus(2'd2, 16'hFFFF, 16'h0000, 1'b1, 8'h33);
        waitResults("adc_wrap", {8'h33, 4'b0101, 16'h0000});
        releaseOutputs("adc_wrap");

        applyStimulus(2'd3, 16'h0000, 16'h0000, 1'b1, 8'h44);
        waitResults("sbb_borrow", {8'h44, 4'b0110, 16'hFFFF});
        releaseOutputs("sbb_borrow");

        // Reset two cycles into a calculation discards it without output.
        applyStimulus(2'd0, 16'h0102, 16'h0304, 1'b0, 8'h55);
        stepClock();
        rst = 1'b1;
        stepClock();
        stepClock();
        for (int g = 0; g < NI; g++) begin
            checkOutput($sformatf("midrst_valid_u%0d", g), 32'(outValid[g]), 32'd0);
            checkOutput($sformatf("midrst_result_u%0d", g), 32'(resultV[g]), 32'd0);
        end
        rst = 1'b0;
        #1;
        for (int g = 0; g < NI; g++)
            checkOutput($sformatf("midrst_ready_u%0d", g), 32'(inReady[g]), 32'd1);
        @(negedge clk);
        seen = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            stepClock();
            if (outValid != '0) seen++;
        end
        checkOutput("midrst_no_result", 32'(seen), 32'd0);

        // Backpressure: hold the result, with a new request waiting.
        expected = refModel(2'd0, 16'hA5A5, 16'h5A5A, 1'b0, 8'h66);
        applyStimulus(2'd0, 16'hA5A5, 16'h5A5A, 1'b0, 8'h66);
        waitResults("bp", expected);
        opT = 2'd3; opaT = 16'h8000; opbT = 16'h0001; cInT = 1'b0; idT = 8'h77;
        inValid = '1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            stepClock();
            for (int g = 0; g < NI; g++) begin
                checkOutput($sformatf("bp_hold_valid_u%0d", g), 32'(outValid[g]), 32'd1);
                checkOutput($sformatf("bp_hold_result_u%0d", g), 32'(resultV[g]), 32'(expected));
                checkOutput($sformatf("bp_hold_ready_u%0d", g), 32'(inReady[g]), 32'd0);
            end
        end
        outReady = '1;
        stepClock();
        outReady = '0;
        for (int g = 0; g < NI; g++) begin
            checkOutput($sformatf("bp_release_ready_u%0d", g), 32'(inReady[g]), 32'd1);
            checkOutput($sformatf("bp_release_valid_u%0d", g), 32'(outValid[g]), 32'd0);
        end
        stepClock();
        inValid = '0;
        waitResults("b2b", refModel(2'd3, 16'h8000, 16'h0001, 1'b0, 8'h77));
        releaseOutputs("b2b");

        // Randomised operations across all slice widths.
        for (int n = 0; n < 40; n++) begin
            logic [1:0]    rop;
            logic [DS-1:0] ra;
            logic [DS-1:0] rb;
            logic          rc;
            logic [IS-1:0] rid;
            rop = 2'($urandom_range(0, 3));
            ra  = pickOperand();
            rb  = pickOperand();
            rc  = 1'($urandom_range(0, 1));
            rid = 8'($urandom);
            applyStimulus(rop, ra, rb, rc, rid);
            waitResults($sformatf("rand%0d", n), refModel(rop, ra, rb, rc, rid));
            releaseOutputs($sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
